// File: rtl/prim_memarb.sv
// prim_memarb -- two-port memory arbiter and access sequencer.
//
// Arbitrates between two byte-addressed requesters (port 0: CPU, port 1:
// DMA/debug loader) and sequences each access onto a single 16-bit-wide
// synchronous SRAM. Unaligned 16-bit accesses are split into two word cycles.
// Every transaction completes with a one-cycle acknowledge to its port.
//
// Parameters
//   FIXED_PRIO   0 = round-robin on simultaneous requests, 1 = port 0 wins
//
// Ports
//   i_clk, i_reset_n          clock (rising edge), async active-low reset
//   i_pN_req                  request, held with attributes until ack
//   i_pN_addr / i_pN_dat      byte address / little-endian write data
//   i_pN_bs                   byte select: 01 byte, 11 16-bit, else no-op
//   i_pN_we                   1 = write
//   o_pN_ack / o_pN_dat       completion pulse / read data (0 when no ack)
//   o_mem_en/we/addr/be/dat   SRAM cycle strobe, write, word addr, lanes, data
//   i_mem_dat                 SRAM read data, valid the cycle after a read
//   o_busy                    high whenever a transaction is in progress
module prim_memarb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_p0_req,
  input  logic [15:0] i_p0_addr,
  input  logic [15:0] i_p0_dat,
  input  logic [1:0]  i_p0_bs,
  input  logic        i_p0_we,
  input  logic        i_p1_req,
  input  logic [15:0] i_p1_addr,
  input  logic [15:0] i_p1_dat,
  input  logic [1:0]  i_p1_bs,
  input  logic        i_p1_we,
  output logic        o_p0_ack,
  output logic [15:0] o_p0_dat,
  output logic        o_p1_ack,
  output logic [15:0] o_p1_dat,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [14:0] o_mem_addr,
  output logic [1:0]  o_mem_be,
  output logic [15:0] o_mem_dat,
  input  logic [15:0] i_mem_dat,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] addr_q;
  logic [15:0] dat_q;
  logic [1:0]  bs_q;
  logic        we_q;
  logic        port_q;   // port owning the current transaction
  logic        last_q;   // port granted most recently
  logic [7:0]  hold_q;   // low result byte of a split read

  // Grant selection and the attributes of the winning port
  logic        gnt_port_d;
  logic [15:0] addr_d;
  logic [15:0] dat_d;
  logic [1:0]  bs_d;
  logic        we_d;

  always_comb begin
    gnt_port_d = 1'b0;
    if (i_p0_req && i_p1_req) begin
      gnt_port_d = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      gnt_port_d = i_p1_req;
    end
    addr_d = gnt_port_d ? i_p1_addr : i_p0_addr;
    dat_d  = gnt_port_d ? i_p1_dat  : i_p0_dat;
    bs_d   = gnt_port_d ? i_p1_bs   : i_p0_bs;
    we_d   = gnt_port_d ? i_p1_we   : i_p0_we;
  end

  // Decodes of the latched request
  logic        is_byte;
  logic        is_word;
  logic        is_split;
  logic [14:0] word_addr;

  assign is_byte   = (bs_q == 2'b01);
  assign is_word   = (bs_q == 2'b11);
  assign is_split  = is_word & addr_q[0];
  assign word_addr = addr_q[15:1];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dat_q   <= '0;
      bs_q    <= '0;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_p0_req || i_p1_req) begin
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            bs_q    <= bs_d;
            we_q    <= we_d;
            port_q  <= gnt_port_d;
            last_q  <= gnt_port_d;
            state_q <= ACC1;
          end
        end
        ACC1: state_q <= is_split ? ACC2 : DONE;
        ACC2: begin
          // Data returned here is from the ACC1 word; its upper byte is the
          // byte at the odd start address.
          if (!we_q) begin
            hold_q <= i_mem_dat[15:8];
          end
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode only state and holding registers (plus SRAM read data for
  // the returned result), never the live request inputs.
  logic [15:0] rdata;

  always_comb begin
    o_mem_en   = 1'b0;
    o_mem_we   = 1'b0;
    o_mem_addr = '0;
    o_mem_be   = '0;
    o_mem_dat  = '0;
    o_p0_ack   = 1'b0;
    o_p1_ack   = 1'b0;
    o_p0_dat   = '0;
    o_p1_dat   = '0;
    rdata      = '0;

    case (state_q)
      ACC1: begin
        o_mem_addr = word_addr;
        if (is_byte) begin
          o_mem_en  = 1'b1;
          o_mem_we  = we_q;
          o_mem_be  = addr_q[0] ? 2'b10 : 2'b01;
          o_mem_dat = {dat_q[7:0], dat_q[7:0]};
        end else if (is_word) begin
          o_mem_en  = 1'b1;
          o_mem_we  = we_q;
          o_mem_be  = addr_q[0] ? 2'b10 : 2'b11;
          o_mem_dat = addr_q[0] ? {dat_q[7:0], 8'h00} : dat_q;
        end
      end
      ACC2: begin
        o_mem_en   = 1'b1;
        o_mem_we   = we_q;
        o_mem_addr = word_addr + 15'd1;
        o_mem_be   = 2'b01;
        o_mem_dat  = {8'h00, dat_q[15:8]};
      end
      DONE: begin
        if (!we_q) begin
          if (is_byte) begin
            rdata = {8'h00, addr_q[0] ? i_mem_dat[15:8] : i_mem_dat[7:0]};
          end else if (is_split) begin
            rdata = {i_mem_dat[7:0], hold_q};
          end else if (is_word) begin
            rdata = i_mem_dat;
          end
        end
        o_p0_ack = ~port_q;
        o_p1_ack = port_q;
        o_p0_dat = port_q ? 16'h0000 : rdata;
        o_p1_dat = port_q ? rdata : 16'h0000;
      end
      default: ;
    endcase
  end

  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_prim_memarb.sv
module tb_prim_memarb;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p1_req;
  logic [15:0] p0_addr, p1_addr, p0_dat, p1_dat;
  logic [1:0]  p0_bs, p1_bs;
  logic        p0_we, p1_we;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdat, p1_rdat;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdat, mem_rd;
  logic        busy;

  // Second instance with fixed priority; only writes, so no SRAM behind it
  logic        f_p0_req, f_p1_req;
  logic [15:0] f_p0_addr, f_p1_addr, f_p0_dat, f_p1_dat;
  logic        f_p0_ack, f_p1_ack;
  logic [15:0] f_p0_rdat, f_p1_rdat;
  logic        f_mem_en, f_mem_we;
  logic [14:0] f_mem_addr;
  logic [1:0]  f_mem_be;
  logic [15:0] f_mem_wdat, f_mem_rd;
  logic        f_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port;
    logic [15:0] dat;
  } exp_t;
  exp_t sb[$];

  prim_memarb #(.FIXED_PRIO(1'b0)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_dat(p0_dat), .i_p0_bs(p0_bs), .i_p0_we(p0_we),
    .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_dat(p1_dat), .i_p1_bs(p1_bs), .i_p1_we(p1_we),
    .o_p0_ack(p0_ack), .o_p0_dat(p0_rdat), .o_p1_ack(p1_ack), .o_p1_dat(p1_rdat),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
    .o_mem_dat(mem_wdat), .i_mem_dat(mem_rd), .o_busy(busy)
  );

  prim_memarb #(.FIXED_PRIO(1'b1)) dut_fp (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_p0_req(f_p0_req), .i_p0_addr(f_p0_addr), .i_p0_dat(f_p0_dat), .i_p0_bs(2'b11), .i_p0_we(1'b1),
    .i_p1_req(f_p1_req), .i_p1_addr(f_p1_addr), .i_p1_dat(f_p1_dat), .i_p1_bs(2'b11), .i_p1_we(1'b1),
    .o_p0_ack(f_p0_ack), .o_p0_dat(f_p0_rdat), .o_p1_ack(f_p1_ack), .o_p1_dat(f_p1_rdat),
    .o_mem_en(f_mem_en), .o_mem_we(f_mem_we), .o_mem_addr(f_mem_addr), .o_mem_be(f_mem_be),
    .o_mem_dat(f_mem_wdat), .i_mem_dat(f_mem_rd), .o_busy(f_busy)
  );

  assign f_mem_rd = 16'h0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model with a bench-only preload port
  logic [15:0] mem [0:32767];
  logic        pl_en;
  logic [14:0] pl_addr;
  logic [15:0] pl_dat;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_dat;
    end else if (mem_en) begin
      if (mem_we) begin
        if (mem_be[0]) mem[mem_addr][7:0]  <= mem_wdat[7:0];
        if (mem_be[1]) mem[mem_addr][15:8] <= mem_wdat[15:8];
      end else begin
        mem_rd <= mem[mem_addr];
      end
    end
  end

  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One transaction on dut with explicit expected SRAM cycles; read data via scoreboard
  task automatic txn(input bit port, input logic [15:0] addr, input logic [15:0] wdat,
                     input logic [1:0] bs, input bit we, input int exp_lat,
                     input logic [14:0] a1, input logic [1:0] be1, input logic [15:0] d1,
                     input logic [14:0] a2, input logic [15:0] d2, input logic [15:0] rexp);
    bit   acked = 1'b0;
    bit   en1;
    exp_t e;
    en1 = (be1 != 2'b00);
    sb.push_back('{port: port, dat: rexp});
    if (port) begin
      p1_req = 1'b1; p1_addr = addr; p1_dat = wdat; p1_bs = bs; p1_we = we;
    end else begin
      p0_req = 1'b1; p0_addr = addr; p0_dat = wdat; p0_bs = bs; p0_we = we;
    end
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_be} !== {en1, we & en1, a1, be1}) begin
          errors++;
          $display("FAIL acc1_cycle addr=%h: en/we/addr/be = %b/%b/%h/%b, required %b/%b/%h/%b",
                   addr, mem_en, mem_we, mem_addr, mem_be, en1, we & en1, a1, be1);
        end
        if (we) begin
          checks++;
          if (mem_wdat !== d1) begin
            errors++;
            $display("FAIL acc1_wdat addr=%h: got %h, required %h", addr, mem_wdat, d1);
          end
        end
        checks++;
        if ({p0_ack, p1_ack, p0_rdat, p1_rdat, busy} !== {2'b00, 32'h0, 1'b1}) begin
          errors++;
          $display("FAIL acc1_idle_outputs: ack=%b%b dat=%h/%h busy=%b, required 00 0000/0000 1",
                   p0_ack, p1_ack, p0_rdat, p1_rdat, busy);
        end
      end
      if (c == 2 && exp_lat == 3) begin
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_be} !== {1'b1, we, a2, 2'b01}) begin
          errors++;
          $display("FAIL acc2_cycle addr=%h: en/we/addr/be = %b/%b/%h/%b, required 1/%b/%h/01",
                   addr, mem_en, mem_we, mem_addr, mem_be, we, a2);
        end
        if (we) begin
          checks++;
          if (mem_wdat !== d2) begin
            errors++;
            $display("FAIL acc2_wdat addr=%h: got %h, required %h", addr, mem_wdat, d2);
          end
        end
      end
      if (p0_ack || p1_ack) begin
        acked = 1'b1;
        e = sb.pop_front();
        checks++;
        if (c != exp_lat || p0_ack !== ~e.port || p1_ack !== e.port || mem_en !== 1'b0) begin
          errors++;
          $display("FAIL ack_timing addr=%h: ack=%b%b at cycle %0d mem_en=%b, required port %0d at cycle %0d mem_en=0",
                   addr, p0_ack, p1_ack, c, mem_en, e.port, exp_lat);
        end
        checks++;
        if ((e.port ? p1_rdat : p0_rdat) !== e.dat || (e.port ? p0_rdat : p1_rdat) !== 16'h0000) begin
          errors++;
          $display("FAIL read_data addr=%h: p0=%h p1=%h, required port %0d = %h, other 0000",
                   addr, p0_rdat, p1_rdat, e.port, e.dat);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        break;
      end
    end
    if (!acked) begin
      checks++; errors++;
      void'(sb.pop_front());
      $display("FAIL ack_timeout addr=%h: no ack in 10 cycles, required cycle %0d", addr, exp_lat);
      p0_req = 1'b0; p1_req = 1'b0;
    end
    @(posedge clk); #1;   // leave DONE -> IDLE
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, mem_en, mem_we, mem_addr, mem_be, mem_wdat, p0_ack, p1_ack, p0_rdat, p1_rdat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b en=%b we=%b addr=%h be=%b wdat=%h ack=%b%b dat=%h/%h, required all 0",
               busy, mem_en, mem_we, mem_addr, mem_be, mem_wdat, p0_ack, p1_ack, p0_rdat, p1_rdat);
    end
    checks++;
    if ({f_busy, f_mem_en, f_p0_ack, f_p1_ack} !== 4'b0) begin
      errors++;
      $display("FAIL reset_fp_outputs: busy/en/acks=%b%b%b%b, required 0000", f_busy, f_mem_en, f_p0_ack, f_p1_ack);
    end
    preload(15'h0010, 16'hBEEF);
    preload(15'h0011, 16'h0000);
    preload(15'h7FFF, 16'hAA00);
    preload(15'h0000, 16'h00BB);
    preload(15'h0002, 16'h0000);
    preload(15'h0020, 16'h5A5A);
    preload(15'h0021, 16'hC0DE);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned_read();
    txn(1'b0, 16'h0020, 16'h0000, 2'b11, 1'b0, 2, 15'h0010, 2'b11, 16'h0, 15'h0, 16'h0, 16'hBEEF);
  endtask

  task automatic test_unaligned();
    txn(1'b0, 16'h0021, 16'h1234, 2'b11, 1'b1, 3, 15'h0010, 2'b10, 16'h3400, 15'h0011, 16'h0012, 16'h0000);
    checks++;
    if (mem[15'h0010] !== 16'h34EF || mem[15'h0011] !== 16'h0012) begin
      errors++;
      $display("FAIL split_write_mem: words 10/11 = %h/%h, required 34EF/0012", mem[15'h0010], mem[15'h0011]);
    end
    txn(1'b0, 16'h0021, 16'h0000, 2'b11, 1'b0, 3, 15'h0010, 2'b10, 16'h0, 15'h0011, 16'h0, 16'h1234);
  endtask

  task automatic test_wrap();
    txn(1'b1, 16'hFFFF, 16'h0000, 2'b11, 1'b0, 3, 15'h7FFF, 2'b10, 16'h0, 15'h0000, 16'h0, 16'hBBAA);
  endtask

  task automatic test_byte_lanes();
    txn(1'b0, 16'h0005, 16'h00C3, 2'b01, 1'b1, 2, 15'h0002, 2'b10, 16'hC3C3, 15'h0, 16'h0, 16'h0000);
    txn(1'b0, 16'h0005, 16'h0000, 2'b01, 1'b0, 2, 15'h0002, 2'b10, 16'h0, 15'h0, 16'h0, 16'h00C3);
    txn(1'b1, 16'h0004, 16'hFF77, 2'b01, 1'b1, 2, 15'h0002, 2'b01, 16'h7777, 15'h0, 16'h0, 16'h0000);
    txn(1'b1, 16'h0004, 16'h0000, 2'b01, 1'b0, 2, 15'h0002, 2'b01, 16'h0, 15'h0, 16'h0, 16'h0077);
    txn(1'b0, 16'h0004, 16'h0000, 2'b11, 1'b0, 2, 15'h0002, 2'b11, 16'h0, 15'h0, 16'h0, 16'hC377);
  endtask

  task automatic test_noop();
    txn(1'b1, 16'h0030, 16'h1111, 2'b00, 1'b1, 2, 15'h0018, 2'b00, 16'h0, 15'h0, 16'h0, 16'h0000);
    txn(1'b1, 16'h0020, 16'h0000, 2'b10, 1'b0, 2, 15'h0010, 2'b00, 16'h0, 15'h0, 16'h0, 16'h0000);
  endtask

  // Both ports request continuously; last grant was port 1, so p0 leads.
  task automatic test_round_robin();
    int   n = 0;
    int   last_c = 0;
    exp_t e;
    sb.push_back('{port: 1'b0, dat: 16'h5A5A});
    sb.push_back('{port: 1'b1, dat: 16'hC0DE});
    sb.push_back('{port: 1'b0, dat: 16'h5A5A});
    sb.push_back('{port: 1'b1, dat: 16'hC0DE});
    p0_addr = 16'h0040; p0_bs = 2'b11; p0_we = 1'b0;
    p1_addr = 16'h0042; p1_bs = 2'b11; p1_we = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack) begin
        e = sb.pop_front();
        checks++;
        if (p0_ack !== ~e.port || p1_ack !== e.port) begin
          errors++;
          $display("FAIL rr_grant #%0d: ack=%b%b, required port %0d", n, p0_ack, p1_ack, e.port);
        end
        checks++;
        if ((e.port ? p1_rdat : p0_rdat) !== e.dat) begin
          errors++;
          $display("FAIL rr_data #%0d: got %h, required %h", n, e.port ? p1_rdat : p0_rdat, e.dat);
        end
        checks++;
        if ((n == 0 && c != 2) || (n > 0 && c - last_c != 3)) begin
          errors++;
          $display("FAIL rr_spacing #%0d: ack at cycle %0d (previous %0d), required 2 then every 3", n, c, last_c);
        end
        last_c = c;
        n++;
        if (n == 4) begin
          p0_req = 1'b0; p1_req = 1'b0;
        end
      end
    end
    if (n < 4) begin
      checks++; errors++;
      $display("FAIL rr_timeout: %0d acks seen, required 4", n);
      while (sb.size() > 0) void'(sb.pop_front());
      p0_req = 1'b0; p1_req = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Fixed priority: p0 keeps winning while it requests, then p1 is served.
  task automatic test_fixed_prio();
    int n = 0;
    bit exp_port;
    f_p0_addr = 16'h0100; f_p0_dat = 16'hA5A5;
    f_p1_addr = 16'h0200; f_p1_dat = 16'h5A5A;
    f_p0_req = 1'b1; f_p1_req = 1'b1;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        checks++;
        if ({f_mem_en, f_mem_we, f_mem_addr, f_mem_be, f_mem_wdat} !== {2'b11, 15'h0080, 2'b11, 16'hA5A5}) begin
          errors++;
          $display("FAIL fp_first_cycle: en/we/addr/be/dat = %b/%b/%h/%b/%h, required 1/1/0080/11/a5a5",
                   f_mem_en, f_mem_we, f_mem_addr, f_mem_be, f_mem_wdat);
        end
      end
      if (f_p0_ack || f_p1_ack) begin
        exp_port = (n == 3);
        checks++;
        if (f_p0_ack !== ~exp_port || f_p1_ack !== exp_port || {f_p0_rdat, f_p1_rdat} !== 32'h0) begin
          errors++;
          $display("FAIL fp_grant #%0d: ack=%b%b dat=%h/%h, required port %0d dat 0000/0000",
                   n, f_p0_ack, f_p1_ack, f_p0_rdat, f_p1_rdat, exp_port);
        end
        n++;
        if (n == 3) f_p0_req = 1'b0;
        if (n == 4) f_p1_req = 1'b0;
      end
    end
    if (n < 4) begin
      checks++; errors++;
      $display("FAIL fp_timeout: %0d acks seen, required 4", n);
    end
    f_p0_req = 1'b0; f_p1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reset during ACC2 of a split read aborts it; last grant returns to port 1.
  task automatic test_reset_abort();
    bit seen_ack = 1'b0;
    p0_addr = 16'h0021; p0_bs = 2'b11; p0_we = 1'b0; p0_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, mem_en, mem_addr} !== {2'b11, 15'h0011}) begin
      errors++;
      $display("FAIL abort_in_acc2: busy/en/addr = %b/%b/%h, required 1/1/0011", busy, mem_en, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, mem_en, p0_ack, p1_ack} !== 4'b0) begin
      errors++;
      $display("FAIL abort_immediate: busy/en/acks = %b%b%b%b, required 0000", busy, mem_en, p0_ack, p1_ack);
    end
    p0_req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack || busy) seen_ack = 1'b1;
    end
    checks++;
    if (seen_ack) begin
      errors++;
      $display("FAIL abort_no_ack: ack or busy seen during reset, required none");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{port: 1'b0, dat: 16'h5A5A});
    p0_addr = 16'h0040; p1_addr = 16'h0042; p1_bs = 2'b11; p1_we = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    seen_ack = 1'b0;
    for (int c = 1; c <= 10 && !seen_ack; c++) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack) begin
        exp_t e;
        seen_ack = 1'b1;
        e = sb.pop_front();
        checks++;
        if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdat !== e.dat) begin
          errors++;
          $display("FAIL post_reset_grant: ack=%b%b p0_dat=%h, required ack 10 p0_dat %h",
                   p0_ack, p1_ack, p0_rdat, e.dat);
        end
        p0_req = 1'b0; p1_req = 1'b0;
      end
    end
    if (!seen_ack) begin
      checks++; errors++;
      void'(sb.pop_front());
      $display("FAIL post_reset_timeout: no ack in 10 cycles, required port 0 ack");
      p0_req = 1'b0; p1_req = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b0; p0_addr = '0; p0_dat = '0; p0_bs = '0; p0_we = 1'b0;
    p1_req = 1'b0; p1_addr = '0; p1_dat = '0; p1_bs = '0; p1_we = 1'b0;
    f_p0_req = 1'b0; f_p0_addr = '0; f_p0_dat = '0;
    f_p1_req = 1'b0; f_p1_addr = '0; f_p1_dat = '0;
    pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
    #2;
    test_reset();
    test_aligned_read();
    test_unaligned();
    test_wrap();
    test_byte_lanes();
    test_noop();
    test_round_robin();
    test_fixed_prio();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
